net_test_pulser: RTL

NET_TEST_PULSER -- requirements
Module: net_test_pulser

---
 rtl/net_test_pkg.sv | 26 ++
 rtl/net_test_pulse_timer.sv | 27 ++
 rtl/net_test_pulser.sv | 138 +++++++++++++
 3 files changed

// File: rtl/net_test_pkg.sv
// Shared definitions for the net test pulser: register map, bit positions
// and the pulse FSM state type.
package net_test_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_HIGH   = 3'd1;
  localparam logic [2:0] ADDR_LOW    = 3'd2;
  localparam logic [2:0] ADDR_REPEAT = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  localparam int CTRL_START  = 0;
  localparam int CTRL_STOP   = 1;
  localparam int CTRL_IDLE   = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_CNT_LSB = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/net_test_pulse_timer.sv
// Loadable down-counter; tc flags that the current phase is in its last cycle.
module net_test_pulse_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/net_test_pulser.sv
// Avalon-MM programmable pulse-train generator with done interrupt.
module net_test_pulser
  import net_test_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port,
  output logic        irq
);

  state_t           state, state_next;
  logic             idle_level, irq_en, done;
  logic [CNT_W-1:0] high_cyc, low_cyc, rep_cyc, pulses, pulses_inc;
  logic             wr, ctrl_wr, busy, start_req, stop_req, launch;
  logic             idle_next, out_next, pulse_end, train_end;
  logic             tc, tmr_load, tmr_dec;
  logic [CNT_W-1:0] tmr_val;
  logic             unused_wdata;

  assign wr         = chipselect && !write_n;
  assign ctrl_wr    = wr && (address == ADDR_CTRL);
  assign start_req  = ctrl_wr && writedata[CTRL_START];
  assign stop_req   = ctrl_wr && writedata[CTRL_STOP];
  assign busy       = (state != ST_IDLE);
  assign launch     = !busy && start_req && !stop_req;
  assign idle_next  = (ctrl_wr && !busy) ? writedata[CTRL_IDLE] : idle_level;
  assign pulses_inc = pulses + CNT_W'(1);
  assign pulse_end  = (state == ST_LOW) && tc && !stop_req;
  assign train_end  = pulse_end && (rep_cyc != '0) && (pulses_inc == rep_cyc);
  assign irq        = done && irq_en;
  assign unused_wdata = ^writedata[31:CNT_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_level <= 1'b0;
      irq_en     <= 1'b0;
      high_cyc   <= CNT_W'(1);
      low_cyc    <= CNT_W'(1);
      rep_cyc    <= CNT_W'(1);
      pulses     <= '0;
      done       <= 1'b0;
    end else begin
      idle_level <= idle_next;
      if (ctrl_wr) irq_en <= writedata[CTRL_IRQ_EN];
      if (wr && !busy) begin
        case (address)
          ADDR_HIGH:   high_cyc <= writedata[CNT_W-1:0];
          ADDR_LOW:    low_cyc  <= writedata[CNT_W-1:0];
          ADDR_REPEAT: rep_cyc  <= writedata[CNT_W-1:0];
          default: ;
        endcase
      end
      if (launch) pulses <= '0;
      else if (pulse_end) pulses <= pulses_inc;
      // Later assignments win: completion set beats a same-edge clear.
      if (wr && address == ADDR_STATUS && writedata[STAT_DONE]) done <= 1'b0;
      if (launch) done <= 1'b0;
      if (train_end) done <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      out_port <= 1'b0;
    end else begin
      state    <= state_next;
      out_port <= out_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (launch) state_next = ST_HIGH;
      ST_HIGH: begin
        if (stop_req) state_next = ST_IDLE;
        else if (tc) state_next = ST_LOW;
      end
      ST_LOW: begin
        if (stop_req) state_next = ST_IDLE;
        else if (tc) state_next = train_end ? ST_IDLE : ST_HIGH;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Timer holds remaining cycles minus one, so a zero-length phase still lasts one cycle.
  always_comb begin
    out_next = (state_next == ST_HIGH) ? !idle_next : idle_level;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = busy;
    if (state_next == ST_HIGH && state != ST_HIGH) begin
      tmr_load = 1'b1;
      tmr_val  = (high_cyc == '0) ? '0 : high_cyc - CNT_W'(1);
    end else if (state_next == ST_LOW && state == ST_HIGH) begin
      tmr_load = 1'b1;
      tmr_val  = (low_cyc == '0) ? '0 : low_cyc - CNT_W'(1);
    end
  end

  net_test_pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .tc       (tc)
  );

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_IDLE]   = idle_level;
        readdata[CTRL_IRQ_EN] = irq_en;
      end
      ADDR_HIGH:   readdata[CNT_W-1:0] = high_cyc;
      ADDR_LOW:    readdata[CNT_W-1:0] = low_cyc;
      ADDR_REPEAT: readdata[CNT_W-1:0] = rep_cyc;
      ADDR_STATUS: begin
        readdata[STAT_BUSY]            = busy;
        readdata[STAT_DONE]            = done;
        readdata[STAT_CNT_LSB +: CNT_W] = pulses;
      end
      default: ;
    endcase
  end

endmodule
